// File: rtl/cpumc_arb.sv
// cpumc_arb: shared-bus arbiter with optional master-0 preemptive priority and
// per-grant burst limit. Read data returns two cycles after a read beat, tagged to its master.
module cpumc_arb #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int PRIO0       = 1,
    parameter int MAX_BURST   = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [NUM_MASTERS-1:0]      req_in,
    input  logic [NUM_MASTERS-1:0]      r_nw_in,
    input  logic [NUM_MASTERS*AW-1:0]   a_in,
    input  logic [NUM_MASTERS*DW-1:0]   d_in,
    output logic [NUM_MASTERS-1:0]      gnt_out,
    output logic                        bus_vld_out,
    output logic [AW-1:0]               bus_a_out,
    output logic                        bus_r_nw_out,
    output logic [DW-1:0]               bus_d_out,
    input  logic [DW-1:0]               bus_d_in,
    output logic [DW-1:0]               rd_d_out,
    output logic [NUM_MASTERS-1:0]      rd_vld_out
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST) + 1 : 1;
    localparam logic [IW-1:0] LAST_INIT = IW'(NUM_MASTERS - 1);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0] gnt;
    logic             beat;
    logic             preempt;
    logic             limit_hit;
    logic             arb_any;
    logic [IW-1:0]    arb_idx;
    logic [IW-1:0]    cand_idx;
    int               cand;

    logic             rd_vld_p1;
    logic [IW-1:0]    rd_tag_p1;

    function automatic logic [CW-1:0] burst_sat_inc(input logic [CW-1:0] c, input logic inc);
        if (inc && (c != {CW{1'b1}}))
            return c + 1'b1;
        return c;
    endfunction

    // Master 0 wins outright when prioritised; otherwise rotate from the last owner.
    always_comb begin
        arb_any  = 1'b0;
        arb_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        if ((PRIO0 != 0) && req_in[0]) begin
            arb_any = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                cand     = (int'(last_q) + k) % NUM_MASTERS;
                cand_idx = IW'(cand);
                if (!arb_any && req_in[cand_idx]) begin
                    arb_any = 1'b1;
                    arb_idx = cand_idx;
                end
            end
        end
    end

    always_comb begin
        preempt   = (PRIO0 != 0) && req_in[0] && (owner_q != '0);
        limit_hit = (MAX_BURST != 0)
                    && !((PRIO0 != 0) && (owner_q == '0) && req_in[0])
                    && ((int'(cnt_q) + int'(beat)) >= MAX_BURST);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LAST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = OWN;
                    owner_d = arb_idx;
                    last_d  = arb_idx;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                if (req_in[owner_q] && !preempt && !limit_hit) begin
                    cnt_d = burst_sat_inc(cnt_q, beat);
                end else if (arb_any) begin
                    owner_d = arb_idx;
                    last_d  = arb_idx;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt          = (state_q == OWN) ? (NUM_MASTERS'(1) << owner_q) : '0;
        beat         = |(gnt & req_in);
        bus_a_out    = '0;
        bus_r_nw_out = 1'b1;
        bus_d_out    = '0;
        if (beat) begin
            bus_a_out    = a_in[int'(owner_q)*AW +: AW];
            bus_r_nw_out = r_nw_in[owner_q];
            bus_d_out    = d_in[int'(owner_q)*DW +: DW];
        end
    end

    assign gnt_out     = gnt;
    assign bus_vld_out = beat;

    // p1: read beat issued, slave data arrives during this stage
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_vld_p1  <= 1'b0;
            rd_vld_out <= '0;
            rd_d_out   <= '0;
        end else begin
            rd_vld_p1  <= beat && bus_r_nw_out;
            rd_vld_out <= rd_vld_p1 ? (NUM_MASTERS'(1) << rd_tag_p1) : '0;
            if (rd_vld_p1)
                rd_d_out <= bus_d_in;
        end
    end

    always_ff @(posedge clk_in) begin
        rd_tag_p1 <= owner_q;
    end

endmodule

// File: tb/tb_cpumc_arb.sv
// Directed bench for cpumc_arb: a 2-master prioritised instance (burst 2) and a
// 4-master round-robin instance (burst 4), checked against hand-computed vectors.
module tb_cpumc_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        a_rst;
    logic [1:0]  a_req, a_rnw, a_gnt, a_rdv;
    logic [31:0] a_a;
    logic [15:0] a_d, a_ba;
    logic        a_bvld, a_brnw;
    logic [7:0]  a_bd, a_bdin, a_rdd;

    logic        b_rst;
    logic [3:0]  b_req, b_rnw, b_gnt, b_rdv;
    logic [63:0] b_a;
    logic [31:0] b_d;
    logic [15:0] b_ba;
    logic        b_bvld, b_brnw;
    logic [7:0]  b_bd, b_bdin, b_rdd;

    cpumc_arb #(.NUM_MASTERS(2), .AW(16), .DW(8), .PRIO0(1), .MAX_BURST(2)) dut_a (
        .clk_in(clk), .rst_in(a_rst), .req_in(a_req), .r_nw_in(a_rnw), .a_in(a_a), .d_in(a_d),
        .gnt_out(a_gnt), .bus_vld_out(a_bvld), .bus_a_out(a_ba), .bus_r_nw_out(a_brnw),
        .bus_d_out(a_bd), .bus_d_in(a_bdin), .rd_d_out(a_rdd), .rd_vld_out(a_rdv)
    );

    cpumc_arb #(.NUM_MASTERS(4), .AW(16), .DW(8), .PRIO0(0), .MAX_BURST(4)) dut_b (
        .clk_in(clk), .rst_in(b_rst), .req_in(b_req), .r_nw_in(b_rnw), .a_in(b_a), .d_in(b_d),
        .gnt_out(b_gnt), .bus_vld_out(b_bvld), .bus_a_out(b_ba), .bus_r_nw_out(b_brnw),
        .bus_d_out(b_bd), .bus_d_in(b_bdin), .rd_d_out(b_rdd), .rd_vld_out(b_rdv)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nextcyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Preemption scenario on instance A, one entry per cycle.
    logic [1:0] p_req  [13] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0] p_gnt  [13] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
    logic       p_bvld [13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] p_rdv  [13] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};

    logic [7:0]  exp_rdd;
    logic [15:0] exp_ba;
    logic [3:0]  exp_g;
    int          own;

    initial begin
        a_rst = 1'b1; a_req = '0; a_rnw = '0; a_a = '0; a_d = '0; a_bdin = '0;
        b_rst = 1'b1; b_req = '0; b_rnw = '0; b_a = '0; b_d = '0; b_bdin = '0;
        nextcyc();
        nextcyc();
        a_rst = 1'b0;
        b_rst = 1'b0;
        settle();
        check("rst_a_gnt", a_gnt, 0);
        check("rst_a_rdv", a_rdv, 0);
        check("rst_a_rdd", a_rdd, 0);
        check("rst_a_bvld", a_bvld, 0);
        check("rst_a_brnw", a_brnw, 1);
        check("rst_b_gnt", b_gnt, 0);

        // Single read by m1 at 0x0010, slave returns 0x5A
        nextcyc(); a_req = 2'b10; a_rnw = 2'b10; a_a = {16'h0010, 16'h0000}; settle();
        check("rd_t0_gnt", a_gnt, 0);
        check("rd_t0_bvld", a_bvld, 0);
        nextcyc(); settle();
        check("rd_t1_gnt", a_gnt, 2'b10);
        check("rd_t1_bvld", a_bvld, 1);
        check("rd_t1_ba", a_ba, 16'h0010);
        check("rd_t1_brnw", a_brnw, 1);
        nextcyc(); a_req = 2'b00; a_bdin = 8'h5A; settle();
        check("rd_t2_gnt", a_gnt, 2'b10);
        check("rd_t2_bvld", a_bvld, 0);
        check("rd_t2_ba", a_ba, 0);
        check("rd_t2_rdv", a_rdv, 0);
        nextcyc(); a_bdin = 8'h77; settle();
        check("rd_t3_rdv", a_rdv, 2'b10);
        check("rd_t3_rdd", a_rdd, 8'h5A);
        check("rd_t3_gnt", a_gnt, 0);
        nextcyc(); settle();
        check("rd_t4_rdv", a_rdv, 0);
        check("rd_t4_rdd", a_rdd, 8'h5A);

        // Write by m0: 0x2006 <= 0x3F
        nextcyc(); a_req = 2'b01; a_rnw = 2'b00; a_a = {16'h0000, 16'h2006}; a_d = {8'h00, 8'h3F}; settle();
        check("wr_t0_gnt", a_gnt, 0);
        nextcyc(); settle();
        check("wr_t1_gnt", a_gnt, 2'b01);
        check("wr_t1_bvld", a_bvld, 1);
        check("wr_t1_brnw", a_brnw, 0);
        check("wr_t1_bd", a_bd, 8'h3F);
        check("wr_t1_ba", a_ba, 16'h2006);
        nextcyc(); a_req = 2'b00; settle();
        check("wr_t2_rdv", a_rdv, 0);
        nextcyc(); settle();
        check("wr_t3_rdv", a_rdv, 0);
        check("wr_t3_rdd", a_rdd, 8'h5A);

        // m1 streams reads at 0x8000; m0 raises req and preempts, then holds past its burst limit
        exp_rdd = 8'h5A;
        a_rnw = 2'b11;
        a_a   = {16'h8000, 16'h1234};
        for (int t = 0; t < 13; t++) begin
            nextcyc();
            a_req  = p_req[t];
            a_bdin = 8'(8'h40 + t);
            settle();
            if (p_rdv[t] != 2'b00)
                exp_rdd = 8'(8'h40 + t - 1);
            exp_ba = p_bvld[t] ? ((p_gnt[t] == 2'b01) ? 16'h1234 : 16'h8000) : 16'h0000;
            check($sformatf("pri_gnt_%0d", t), a_gnt, p_gnt[t]);
            check($sformatf("pri_bvld_%0d", t), a_bvld, p_bvld[t]);
            check($sformatf("pri_ba_%0d", t), a_ba, exp_ba);
            check($sformatf("pri_rdv_%0d", t), a_rdv, p_rdv[t]);
            check($sformatf("pri_rdd_%0d", t), a_rdd, exp_rdd);
        end

        // Reset one cycle after a read beat: the return must be dropped
        nextcyc(); a_req = 2'b10; a_rnw = 2'b10; a_a = {16'h0ABC, 16'h0000}; a_bdin = 8'hC3; settle();
        check("rr_t0_gnt", a_gnt, 0);
        nextcyc(); settle();
        check("rr_t1_bvld", a_bvld, 1);
        nextcyc(); a_rst = 1'b1; settle();
        check("rr_t2_rdv", a_rdv, 0);
        nextcyc(); a_rst = 1'b0; a_req = 2'b00; settle();
        check("rr_t3_gnt", a_gnt, 0);
        check("rr_t3_rdv", a_rdv, 0);
        check("rr_t3_rdd", a_rdd, 0);
        nextcyc(); settle();
        check("rr_t4_rdv", a_rdv, 0);
        check("rr_t4_rdd", a_rdd, 0);

        // Instance B: all four request writes, bursts of 4 rotate 0,1,2,3,0
        b_rnw = 4'b0000;
        b_a   = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
        b_d   = 32'h44332211;
        nextcyc(); b_req = 4'hF; settle();
        check("rr4_t0_gnt", b_gnt, 0);
        check("rr4_t0_bvld", b_bvld, 0);
        for (int t = 1; t <= 20; t++) begin
            nextcyc(); settle();
            own   = ((t - 1) / 4) % 4;
            exp_g = 4'(4'b0001 << own);
            check($sformatf("rr4_gnt_%0d", t), b_gnt, exp_g);
            check($sformatf("rr4_bvld_%0d", t), b_bvld, 1);
            check($sformatf("rr4_ba_%0d", t), b_ba, 16'(16'h1000 * (own + 1)));
            check($sformatf("rr4_rdv_%0d", t), b_rdv, 0);
        end
        nextcyc(); b_req = 4'b0000; settle();
        check("rr4_t21_gnt", b_gnt, 4'b0010);
        check("rr4_t21_bvld", b_bvld, 0);
        nextcyc(); settle();
        check("rr4_t22_gnt", b_gnt, 0);
        nextcyc(); b_req = 4'b1001; settle();
        check("rr4_t23_gnt", b_gnt, 0);
        nextcyc(); settle();
        check("rr4_t24_gnt", b_gnt, 4'b1000);
        check("rr4_t24_ba", b_ba, 16'h4000);
        check("rr4_t24_bd", b_bd, 8'h44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
